// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter shared by instruction fetch and load/store.
// Splits 8/16/32-bit accesses into byte cycles and assembles little-endian read data.
module mem_arbiter #(
  parameter int RAM_ADDR_W = 17,
  parameter bit MEM_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  if_flush_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [RAM_ADDR_W-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;

  logic [RAM_ADDR_W-1:0] ram_addr_d;
  logic                  ram_wr_d;
  logic [7:0]            ram_dout_d;
  logic                  if_done_d, mem_done_d;
  logic [31:0]           if_data_d, mem_rdata_d;

  logic                  done_busy, if_ok, grant_mem, grant_if, abort;
  logic                  rd_last, wr_last, more_bytes;
  logic [RAM_ADDR_W-1:0] next_addr;
  logic [1:0]            rd_idx;

  // Address bits above the RAM width never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:RAM_ADDR_W], mem_addr_i[31:RAM_ADDR_W]};

  // A requester sees its done pulse one cycle before it can drop req, so no grant then.
  assign done_busy  = if_done_o | mem_done_o;
  assign if_ok      = if_req_i & ~if_flush_i;
  assign grant_mem  = (state_q == IDLE) & ~done_busy & mem_req_i & (MEM_FIRST | ~if_ok);
  assign grant_if   = (state_q == IDLE) & ~done_busy & if_ok & ~grant_mem;
  assign abort      = (state_q == IF_RD) & if_flush_i;

  // cnt_q is the index of the current busy cycle: 1 in c1, N+1 in the last read cycle.
  assign rd_last    = (cnt_q == nbytes_q + 3'd1);
  assign wr_last    = (cnt_q == nbytes_q);
  assign more_bytes = (cnt_q < nbytes_q);
  assign next_addr  = base_q + RAM_ADDR_W'(cnt_q);
  assign rd_idx     = 2'(cnt_q - 3'd2);

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_mem)     state_d = mem_we_i ? MEM_WR : MEM_RD;
        else if (grant_if) state_d = IF_RD;
      end
      IF_RD:   if (abort || rd_last) state_d = IDLE;
      MEM_RD:  if (rd_last)          state_d = IDLE;
      MEM_WR:  if (wr_last)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_addr_d  = ram_addr_o;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_o;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_o;
    mem_rdata_d = mem_rdata_o;

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          base_d     = mem_addr_i[RAM_ADDR_W-1:0];
          wdata_d    = mem_wdata_i;
          nbytes_d   = (mem_len_i == 2'b00) ? 3'd1 : (mem_len_i == 2'b01) ? 3'd2 : 3'd4;
          cnt_d      = 3'd1;
          rbuf_d     = '0;
          ram_addr_d = mem_addr_i[RAM_ADDR_W-1:0];
          ram_wr_d   = mem_we_i;
          if (mem_we_i) ram_dout_d = mem_wdata_i[7:0];
        end else if (grant_if) begin
          base_d     = if_addr_i[RAM_ADDR_W-1:0];
          nbytes_d   = 3'd4;
          cnt_d      = 3'd1;
          rbuf_d     = '0;
          ram_addr_d = if_addr_i[RAM_ADDR_W-1:0];
        end
      end
      IF_RD, MEM_RD: begin
        // RAM data lags its address by one cycle, so byte k-1 arrives in cycle c(k+1).
        if (!abort) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q >= 3'd2) rbuf_d[{rd_idx, 3'b000} +: 8] = ram_din_i;
          if (more_bytes)    ram_addr_d = next_addr;
          if (rd_last) begin
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_d;
            end
          end
        end
      end
      MEM_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (more_bytes) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = next_addr;
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end else begin
          mem_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      nbytes_q    <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_data_o   <= '0;
      mem_rdata_o <= '0;
    end else begin
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_addr_o  <= ram_addr_d;
      ram_wr_o    <= ram_wr_d;
      ram_dout_o  <= ram_dout_d;
      if_done_o   <= if_done_d;
      mem_done_o  <= mem_done_d;
      if_data_o   <= if_data_d;
      mem_rdata_o <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte-array reference memory predicts read data
// and write traffic; monitors compare every done pulse and RAM write against the queues.
module tb_mem_arbiter;

  localparam int AW       = 17;
  localparam int RAM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_i = 1'b0;
  logic [31:0]   if_addr_i = '0;
  logic          if_flush_i = 1'b0;
  logic [31:0]   if_data_o;
  logic          if_done_o;
  logic          mem_req_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [1:0]    mem_len_i = '0;
  logic [31:0]   mem_addr_i = '0;
  logic [31:0]   mem_wdata_i = '0;
  logic [31:0]   mem_rdata_o;
  logic          mem_done_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_wr_o;
  logic [7:0]    ram_dout_o;
  logic [7:0]    ram_din_i;

  mem_arbiter #(.RAM_ADDR_W(AW), .MEM_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_store; logic [31:0] data; } mem_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_exp_t;

  logic [31:0] if_q[$];
  mem_exp_t    mem_q[$];
  wr_exp_t     wr_q[$];

  logic [7:0]  ram     [RAM_SIZE];
  logic [7:0]  ref_mem [RAM_SIZE];
  bit          ram_go = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] ram_index(input logic [31:0] addr, input int off);
    return AW'(addr + 32'(off));
  endfunction

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[ram_index(addr, i)];
    return r;
  endfunction

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      ref_mem[ram_index(addr, i)] = data[8*i +: 8];
      wr_q.push_back('{ram_index(addr, i), data[8*i +: 8]});
    end
  endfunction

  // RAM model: registered read, write on strobe; sole writer of ram[].
  initial begin
    ram_din_i <= 8'h00;
    wait (ram_go);
    for (int i = 0; i < RAM_SIZE; i++) ram[i] = ref_mem[i];
    forever begin
      @(posedge clk);
      ram_din_i <= ram[ram_addr_o];
      if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
    end
  end

  mem_exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (if_done_o || mem_done_o) check("single_done", {31'b0, if_done_o & mem_done_o}, 32'h0);
    if (if_done_o) begin
      if (if_q.size() == 0) check("if_done_expected", 32'(if_q.size()), 32'd1);
      else                  check("if_data", if_data_o, if_q.pop_front());
    end
    if (mem_done_o) begin
      if (mem_q.size() == 0) check("mem_done_expected", 32'(mem_q.size()), 32'd1);
      else begin
        mon_e = mem_q.pop_front();
        if (!mon_e.is_store) check("mem_rdata", mem_rdata_o, mon_e.data);
      end
    end
  end

  wr_exp_t mon_w;
  always @(negedge clk) begin
    if (ram_wr_o) begin
      if (wr_q.size() == 0) check("wr_expected", 32'(wr_q.size()), 32'd1);
      else begin
        mon_w = wr_q.pop_front();
        check("wr_addr", 32'(ram_addr_o), 32'(mon_w.addr));
        check("wr_data", 32'(ram_dout_o), 32'(mon_w.data));
      end
    end
  end

  task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n = len_bytes(len);
    int k = 0;
    bit seen = 1'b0;
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
    if (we) begin
      ref_write(addr, wdata, n);
      mem_q.push_back('{1'b1, 32'h0});
    end else begin
      mem_q.push_back('{1'b0, ref_read(addr, n)});
    end
    while (!seen && k < 20) begin
      @(posedge clk); #1; k++;
      if (k <= n) check("mem_ram_addr", 32'(ram_addr_o), 32'(ram_index(addr, k - 1)));
      if (k == 1) begin
        // Inputs are latched at grant; scrambling them afterwards must not matter.
        mem_addr_i = $urandom(); mem_wdata_i = $urandom(); mem_len_i = 2'($urandom_range(0, 3));
      end
      seen = mem_done_o;
    end
    check("mem_latency", k, we ? n + 1 : n + 2);
    @(negedge clk);
    mem_req_i = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] addr);
    int k = 0;
    bit seen = 1'b0;
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = addr;
    if_q.push_back(ref_read(addr, 4));
    while (!seen && k < 20) begin
      @(posedge clk); #1; k++;
      if (k <= 4) check("if_ram_addr", 32'(ram_addr_o), 32'(ram_index(addr, k - 1)));
      if (k == 1) if_addr_i = $urandom();
      seen = if_done_o;
    end
    check("if_latency", k, 6);
    @(negedge clk);
    if_req_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_wr"},    32'(ram_wr_o),   32'h0);
    check({tag, "_ram_addr"},  32'(ram_addr_o), 32'h0);
    check({tag, "_ram_dout"},  32'(ram_dout_o), 32'h0);
    check({tag, "_if_done"},   32'(if_done_o),  32'h0);
    check({tag, "_mem_done"},  32'(mem_done_o), 32'h0);
    check({tag, "_if_data"},   if_data_o,       32'h0);
    check({tag, "_mem_rdata"}, mem_rdata_o,     32'h0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    bit  seen;
    for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 8'($urandom());
    ref_mem[17'h10] = 8'h13; ref_mem[17'h11] = 8'h00; ref_mem[17'h12] = 8'h00; ref_mem[17'h13] = 8'h00;
    ref_mem[17'h20] = 8'h34; ref_mem[17'h21] = 8'h12;
    ref_mem[17'h1FFFE] = 8'h11; ref_mem[17'h1FFFF] = 8'h22;
    ref_mem[17'h00000] = 8'h33; ref_mem[17'h00001] = 8'h44;
    ram_go = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Instruction fetch of 13 00 00 00.
    do_if(32'h0000_0010);

    // Word store then byte load from its middle.
    do_mem(1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
    do_mem(1'b0, 2'b00, 32'h0000_0102, 32'h0);

    // Simultaneous requests: MEM wins, IF waits out the done cycle.
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b01; mem_addr_i = 32'h20;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    mem_q.push_back('{1'b0, ref_read(32'h20, 2)});
    if_q.push_back(ref_read(32'h10, 4));
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk); #1; k++;
      seen = mem_done_o;
    end
    check("contend_mem_latency", k, 4);
    @(negedge clk);
    mem_req_i = 1'b0;
    @(posedge clk); #1;
    check("contend_no_grant_in_done", 32'(ram_addr_o), 32'h21);
    @(posedge clk); #1;
    check("contend_if_grant", 32'(ram_addr_o), 32'h10);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk); #1; k++;
      seen = if_done_o;
    end
    check("contend_if_latency", k, 5);
    @(negedge clk);
    if_req_i = 1'b0;

    // Flush in c2 of a fetch: address freezes and no done follows.
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h30;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("flush_c2_addr", 32'(ram_addr_o), 32'h31);
    if_flush_i = 1'b1; if_req_i = 1'b0;
    @(posedge clk); #1;
    check("flush_addr_hold", 32'(ram_addr_o), 32'h31);
    @(negedge clk);
    if_flush_i = 1'b0;
    @(posedge clk); #1;
    check("flush_addr_hold2", 32'(ram_addr_o), 32'h31);
    check("flush_no_done", 32'(if_done_o), 32'h0);
    do_if(32'h0000_0040);

    // Reset sampled at the end of c1 of a word store: only byte 0 reaches RAM.
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
    mem_addr_i = 32'h200; mem_wdata_i = 32'hCAFE_F00D;
    ref_mem[17'h200] = 8'h0D;
    wr_q.push_back('{17'h200, 8'h0D});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_req_i = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_mem(1'b0, 2'b10, 32'h0000_0200, 32'h0);
    do_mem(1'b1, 2'b10, 32'h0000_0200, 32'h1234_5678);
    do_mem(1'b0, 2'b10, 32'h0000_0200, 32'h0);

    // Word load wrapping across the top of the RAM.
    do_mem(1'b0, 2'b10, 32'h0001_FFFE, 32'h0);

    // Randomised mix of fetches, loads and stores.
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [31:0] addr;
      op   = $urandom_range(0, 2);
      addr = $urandom();
      case ($urandom_range(0, 2))
        0:       addr = (addr & 32'hFFFE_0000) | 32'(17'h1FFFC + 17'($urandom_range(0, 3)));
        1:       addr = (addr & 32'hFFFE_0000) | 32'($urandom_range(0, 63));
        default: ;
      endcase
      case (op)
        0:       do_if(addr);
        1:       do_mem(1'b0, 2'($urandom_range(0, 3)), addr, 32'h0);
        default: do_mem(1'b1, 2'($urandom_range(0, 3)), addr, $urandom());
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    check("if_q_drained",  32'(if_q.size()),  32'h0);
    check("mem_q_drained", 32'(mem_q.size()), 32'h0);
    check("wr_q_drained",  32'(wr_q.size()),  32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
